// File: rtl/default_slave_wr_if.sv
// rtl/default_slave_wr_if.sv - AW/W/B channel bundle for the default write slave
//
// Purpose: groups the AXI write-address, write-data and write-response
// signals of the default slave into one interface.
// Modports:
//   master - drives AW*/W*/BREADY_S, observes AWREADY_S/WREADY_S/B*
//   slave  - the reverse; used by default_slave_wr
// Width macros fall back to AXI4-style defaults when not supplied.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

interface default_slave_wr_if;
    logic [`AXI_IDS_BITS-1:0]  AWID_S;
    logic [`AXI_ADDR_BITS-1:0] AWADDR_S;
    logic [`AXI_LEN_BITS-1:0]  AWLEN_S;
    logic [`AXI_SIZE_BITS-1:0] AWSIZE_S;
    logic [1:0]                AWBURST_S;
    logic                      AWVALID_S;
    logic                      AWREADY_S;
    logic [`AXI_DATA_BITS-1:0] WDATA_S;
    logic [`AXI_STRB_BITS-1:0] WSTRB_S;
    logic                      WLAST_S;
    logic                      WVALID_S;
    logic                      WREADY_S;
    logic [`AXI_IDS_BITS-1:0]  BID_S;
    logic [1:0]                BRESP_S;
    logic                      BVALID_S;
    logic                      BREADY_S;

    modport master (
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S,
        input  BID_S, BRESP_S, BVALID_S,
        output BREADY_S
    );

    modport slave (
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S,
        output BID_S, BRESP_S, BVALID_S,
        input  BREADY_S
    );
endinterface

// File: rtl/default_slave_wr.sv
// rtl/default_slave_wr.sv - AXI default write slave answering every burst with RESP_CODE
//
// Purpose: accepts any write burst, swallows its data beats and returns one
// B response carrying the burst ID and RESP_CODE (DECERR by default).
// Ports:
//   ACLK    - clock, rising edge
//   ARESET  - synchronous active-high reset
//   s       - default_slave_wr_if.slave (AW, W and B channels)
//   ERR_CNT - 16-bit saturating count of completed B handshakes; present only
//             when DEFSLV_ERRCNT_EN is defined
// Burst termination relies solely on the latched AWLEN; WLAST_S is ignored.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

module default_slave_wr #(
    parameter logic [1:0] RESP_CODE = 2'b11
) (
    input  logic ACLK,
    input  logic ARESET,
    default_slave_wr_if.slave s
`ifdef DEFSLV_ERRCNT_EN
    ,
    output logic [15:0] ERR_CNT
`endif
);
    localparam int IDW = `AXI_IDS_BITS;
    localparam int LENW = `AXI_LEN_BITS;
    localparam logic [LENW-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  id_q;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] cnt_q;
    logic            awready_q, wready_q, bvalid_q;
    logic [1:0]      bresp_q;
    logic            aw_hs, w_hs, b_hs, last_beat;
    logic            unused_inputs;

    // Handshakes are qualified by the registered ready/valid flags, which
    // are only ever set in their owning state.
    always_comb begin
        aw_hs     = s.AWVALID_S && awready_q;
        w_hs      = s.WVALID_S && wready_q;
        b_hs      = s.BREADY_S && bvalid_q;
        // Compare before incrementing so AWLEN = all ones still ends cleanly.
        last_beat = w_hs && (cnt_q == len_q);
        state_d   = state_q;
        case (state_q)
            IDLE:    if (aw_hs)     state_d = DATA;
            DATA:    if (last_beat) state_d = RESP;
            RESP:    if (b_hs)      state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered from the next state, so they are held low for
    // the whole reset and AWREADY_S appears on the first edge after it.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            id_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            if (aw_hs) begin
                id_q  <= s.AWID_S;
                len_q <= s.AWLEN_S;
                cnt_q <= '0;
            end else if (w_hs && !last_beat) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            awready_q <= (state_d == IDLE);
            wready_q  <= (state_d == DATA);
            bvalid_q  <= (state_d == RESP);
            bresp_q   <= (state_d == RESP) ? RESP_CODE : 2'b00;
        end
    end

    assign s.AWREADY_S = awready_q;
    assign s.WREADY_S  = wready_q;
    assign s.BVALID_S  = bvalid_q;
    assign s.BID_S     = id_q;
    assign s.BRESP_S   = bresp_q;

`ifdef DEFSLV_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            err_cnt_q <= '0;
        end else if (b_hs && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

    assign unused_inputs = ^{s.AWADDR_S, s.AWSIZE_S, s.AWBURST_S,
                             s.WDATA_S, s.WSTRB_S, s.WLAST_S};
endmodule

// File: doc/default_slave_wr.md
DEFAULT_SLAVE_WR -- requirements
Module: default_slave_wr

Interface
REQ-001 The block SHALL have parameter RESP_CODE, default 2'b11 (DECERR), giving the BRESP value returned for every write burst.
REQ-002 The block SHALL have port ACLK, input, 1, the single clock; all logic rising-edge triggered.
REQ-003 The block SHALL have port ARESET, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port AWID_S, input, `AXI_IDS_BITS, the write address ID.
REQ-005 The block SHALL have port AWADDR_S, input, `AXI_ADDR_BITS, the write address, which is ignored.
REQ-006 The block SHALL have port AWLEN_S, input, `AXI_LEN_BITS, the burst length minus 1.
REQ-007 The block SHALL have ports AWSIZE_S (input, `AXI_SIZE_BITS) and AWBURST_S (input, 2), both ignored.
REQ-008 The block SHALL have ports AWVALID_S (input, 1) and AWREADY_S (output, 1), the AW handshake.
REQ-009 The block SHALL have ports WDATA_S (input, `AXI_DATA_BITS) and WSTRB_S (input, `AXI_STRB_BITS), both discarded.
REQ-010 The block SHALL have ports WLAST_S (input, 1), WVALID_S (input, 1) and WREADY_S (output, 1), the W handshake.
REQ-011 The block SHALL have ports BID_S (output, `AXI_IDS_BITS), BRESP_S (output, 2), BVALID_S (output, 1) and BREADY_S (input, 1), the B channel.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, DATA, RESP.
REQ-013 In IDLE, the block SHALL drive AWREADY_S=1, WREADY_S=0 and BVALID_S=0.
REQ-014 When AWVALID_S&&AWREADY_S in IDLE, the block SHALL latch AWID_S and AWLEN_S, clear the beat counter and move to DATA on the next edge.
REQ-015 In DATA, the block SHALL drive WREADY_S=1 and AWREADY_S=0.
REQ-016 In DATA, each WVALID_S&&WREADY_S SHALL increment an `AXI_LEN_BITS-wide beat counter.
REQ-017 The burst SHALL end on the beat where the counter equals the latched AWLEN; the block then moves to RESP.
REQ-018 WLAST_S SHALL NOT affect termination; WLAST_S asserted early or missing SHALL be tolerated without hang or extra beats.
REQ-019 AWLEN=0 SHALL produce exactly one W beat; AWLEN=max (all ones) SHALL produce 2^`AXI_LEN_BITS beats, with the counter not wrapping before the compare.
REQ-020 In RESP, the block SHALL drive BVALID_S=1, BID_S=latched ID and BRESP_S=RESP_CODE, all held stable until BREADY_S.
REQ-021 On BVALID_S&&BREADY_S, the block SHALL return to IDLE so that AWREADY_S=1 on the following cycle.
REQ-022 Latency: AW accepted at edge T gives WREADY_S=1 from T+1; final W beat at edge T+k gives BVALID_S=1 from T+k+1.
REQ-023 W beats presented before the AW handshake SHALL be stalled (WREADY_S=0), never consumed.
REQ-024 AWVALID_S asserted during DATA or RESP SHALL be stalled until the block returns to IDLE.
REQ-025 All outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output path.

Reset
REQ-026 While ARESET=1 at an edge, the FSM SHALL go to IDLE, and the latched ID, latched LEN and beat counter SHALL be cleared to 0.
REQ-027 During reset, AWREADY_S, WREADY_S and BVALID_S SHALL be 0, and BID_S and BRESP_S SHALL be 0.
REQ-028 AWREADY_S SHALL rise on the first edge after ARESET deasserts.
REQ-029 Reset asserted mid-burst or with BVALID_S pending SHALL abandon the transaction, with no response issued afterwards.

Configuration
REQ-030 The macro DEFSLV_ERRCNT_EN SHALL enable the output ERR_CNT, 16 bits wide, that counts completed B handshakes, reset to 0 and saturating at 16'hFFFF.
REQ-031 Without DEFSLV_ERRCNT_EN, the ERR_CNT port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then AW ID=8'h15 LEN=0 -> one W beat accepted, then BVALID with BID=8'h15 and BRESP=2'b11 exactly one cycle after the beat.
REQ-033 LEN=3 with WVALID toggling every other cycle -> exactly 4 beats accepted, WREADY drops after the 4th, and BVALID follows.
REQ-034 LEN=1 with WLAST high on beat 0 -> 2 beats still consumed, then one response.
REQ-035 BREADY held low 5 cycles -> BVALID, BID and BRESP stable for 5 cycles; after the handshake AWREADY=1 the next cycle; a second AW is stalled until then.
REQ-036 ARESET pulsed during beat 2 of a LEN=7 burst -> no BVALID, AWREADY=1 after reset, and ERR_CNT=0 (when enabled).
REQ-037 With DEFSLV_ERRCNT_EN, 3 back-to-back bursts -> ERR_CNT=3; force the count to 16'hFFFF plus one burst -> it remains 16'hFFFF.
